// File: rtl/pixel_pkg.sv
// Shared pixel types, frame geometry and the gray-to-RGB expansion helper.
package pixel_pkg;

    typedef logic [7:0]  gray_t;
    typedef logic [23:0] rgb_t;

    localparam int unsigned IMG_W            = 640;
    localparam int unsigned IMG_H            = 480;
    localparam int unsigned FRAME_PIXELS_DEF = IMG_W * IMG_H;

    function automatic rgb_t gray2rgb(gray_t g);
        return {g, g, g};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Generic gray_t FIFO: registered storage, occupancy counter separates full from empty.
module pixel_fifo
    import pixel_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic  clk,
    input  logic  n_rst,
    input  logic  clear,
    input  logic  push,
    input  gray_t din,
    input  logic  pop,
    output gray_t head,
    output logic  full,
    output logic  empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    gray_t            mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             do_push, do_pop;

    assign full    = (occ_q == OCC_W'(DEPTH));
    assign empty   = (occ_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_q];

    // DEPTH is a power of two, so pointers wrap naturally at PTR_W bits.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/gray_to_rgb_packer.sv
// Re-expands 8-bit gray pixels to 24-bit RGB through a small FIFO, counts frame pixels.
// Optional feature: define BINARIZE_EN to threshold each pixel to black/white at the FIFO output.
module gray_to_rgb_packer
    import pixel_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH   = 4,
    parameter  int unsigned FRAME_PIXELS = FRAME_PIXELS_DEF,
    parameter  gray_t       THRESHOLD    = 8'd128,
    localparam int unsigned CNT_W        = $clog2(FRAME_PIXELS)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic [7:0]       gray_in,
    input  logic             gray_valid,
    output logic             gray_ready,
    output logic [23:0]      rgb_out,
    output logic             rgb_valid,
    input  logic             rgb_ready,
    output logic [CNT_W-1:0] pix_count,
    output logic             frame_done
);

    logic             push, pop, full, empty;
    gray_t            head, h;
    logic [CNT_W-1:0] count_q, count_d;
    logic             done_q, done_d;

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .clear (clear),
        .push  (push),
        .din   (gray_in),
        .pop   (pop),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // clear kills both handshakes in its cycle.
    assign gray_ready = ~full & ~clear;
    assign push       = gray_valid & gray_ready;
    assign rgb_valid  = ~empty;
    assign pop        = rgb_valid & rgb_ready & ~clear;

`ifdef BINARIZE_EN
    assign h = (head >= THRESHOLD) ? 8'hFF : 8'h00;
`else
    logic unused_thr;
    assign unused_thr = ^THRESHOLD;
    assign h          = head;
`endif

    // Storage may hold stale data when empty; force zero.
    assign rgb_out = empty ? '0 : gray2rgb(h);

    always_comb begin
        count_d = count_q;
        done_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (pop) begin
            if (count_q == CNT_W'(FRAME_PIXELS - 1)) begin
                count_d = '0;
                done_d  = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    assign pix_count  = count_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_gray_to_rgb_packer.sv
// Scoreboard bench: accepted inputs queue expected RGB words, an output monitor pops and compares.
module tb_gray_to_rgb_packer;

    localparam int unsigned FP    = 8;
    localparam int unsigned CW    = $clog2(FP);
    localparam int unsigned NPOPS = 22;

    logic          tb_clk = 1'b0;
    logic          n_rst;
    logic          clear;
    logic [7:0]    gray_in;
    logic          gray_valid;
    logic          gray_ready;
    logic [23:0]   rgb_out;
    logic          rgb_valid;
    logic          rgb_ready;
    logic [CW-1:0] pix_count;
    logic          frame_done;

    int            checks = 0;
    int            errors = 0;
    int            n_pops = 0;
    logic [23:0]   sb[$];

    gray_to_rgb_packer #(
        .FIFO_DEPTH   (4),
        .FRAME_PIXELS (FP),
        .THRESHOLD    (8'd128)
    ) dut (
        .clk        (tb_clk),
        .n_rst      (n_rst),
        .clear      (clear),
        .gray_in    (gray_in),
        .gray_valid (gray_valid),
        .gray_ready (gray_ready),
        .rgb_out    (rgb_out),
        .rgb_valid  (rgb_valid),
        .rgb_ready  (rgb_ready),
        .pix_count  (pix_count),
        .frame_done (frame_done)
    );

    always #5 tb_clk = ~tb_clk;

    function automatic logic [23:0] exp_rgb(input logic [7:0] p);
        logic [7:0] h;
`ifdef BINARIZE_EN
        h = (p >= 8'd128) ? 8'hFF : 8'h00;
`else
        h = p;
`endif
        return {h, h, h};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sample away from the active edge; transfers happen at the next rising edge.
    always @(negedge tb_clk) begin
        if (n_rst && !clear) begin
            if (rgb_valid && rgb_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rgb_out unexpected: got %h, expected none", rgb_out);
                end else begin
                    logic [23:0] e;
                    e = sb.pop_front();
                    if (rgb_out !== e) begin
                        errors++;
                        $display("FAIL rgb_out[%0d]: got %h, expected %h", n_pops, rgb_out, e);
                    end
                end
                n_pops++;
            end else if (!rgb_valid) begin
                checks++;
                if (rgb_out !== 24'h0) begin
                    errors++;
                    $display("FAIL rgb_out idle: got %h, expected 000000", rgb_out);
                end
            end
            if (gray_valid && gray_ready) sb.push_back(exp_rgb(gray_in));
        end
    end

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] v);
        gray_in    = v;
        gray_valid = 1'b1;
        tick();
        gray_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst      = 1'b0;
        clear      = 1'b0;
        gray_in    = 8'h33;
        gray_valid = 1'b0;
        rgb_ready  = 1'b1;
        #2;
        // Reset state
        check("reset rgb_valid", 32'(rgb_valid), 0);
        check("reset rgb_out", 32'(rgb_out), 0);
        check("reset pix_count", 32'(pix_count), 0);
        check("reset frame_done", 32'(frame_done), 0);
        check("reset gray_ready", 32'(gray_ready), 1);
        gray_valid = 1'b1;
        tick();
        tick();
        gray_valid = 1'b0;
        n_rst      = 1'b1;
        tick();
        check("no push under reset", 32'(rgb_valid), 0);

        // Single pixel
        send(8'hA5);
        check("single rgb_valid", 32'(rgb_valid), 1);
        check("single rgb_out", 32'(rgb_out), 32'h00A5A5A5);
        tick();
        check("single popped", 32'(rgb_valid), 0);
        check("single pix_count", 32'(pix_count), 1);

        // Backpressure: four fit, fifth waits
        rgb_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            gray_in    = 8'(i);
            gray_valid = 1'b1;
            tick();
        end
        gray_in = 8'h05;
        check("full gray_ready", 32'(gray_ready), 0);
        check("full head", 32'(rgb_out), 32'h00010101);
        tick();
        check("held gray_ready", 32'(gray_ready), 0);
        check("held rgb_out", 32'(rgb_out), 32'h00010101);
        check("held rgb_valid", 32'(rgb_valid), 1);
        rgb_ready = 1'b1;
        tick();
        check("reopen gray_ready", 32'(gray_ready), 1);
        tick();
        gray_valid = 1'b0;
        repeat (4) tick();
        check("drained rgb_valid", 32'(rgb_valid), 0);
        check("backpressure pix_count", 32'(pix_count), 6);

        // Clear to start a fresh frame
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear pix_count", 32'(pix_count), 0);

        // Frame end after 8 transfers
        for (int i = 0; i < 8; i++) begin
            gray_in    = 8'(8'h10 + i);
            gray_valid = 1'b1;
            tick();
        end
        gray_valid = 1'b0;
        check("pre-end pix_count", 32'(pix_count), 7);
        check("pre-end frame_done", 32'(frame_done), 0);
        tick();
        check("frame_done pulse", 32'(frame_done), 1);
        check("wrap pix_count", 32'(pix_count), 0);
        tick();
        check("frame_done single", 32'(frame_done), 0);
        send(8'h42);
        tick();
        check("ninth pix_count", 32'(pix_count), 1);
        check("ninth frame_done", 32'(frame_done), 0);

        // Clear with three queued and pix_count=5
        for (int i = 0; i < 4; i++) begin
            gray_in    = 8'(8'h60 + i);
            gray_valid = 1'b1;
            tick();
        end
        gray_valid = 1'b0;
        tick();
        check("pre-clear pix_count", 32'(pix_count), 5);
        rgb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gray_in    = 8'(8'hA0 + i);
            gray_valid = 1'b1;
            tick();
        end
        gray_valid = 1'b0;
        check("queued rgb_valid", 32'(rgb_valid), 1);
        clear      = 1'b1;
        gray_in    = 8'h99;
        gray_valid = 1'b1;
        rgb_ready  = 1'b1;
        #1;
        check("clear gray_ready", 32'(gray_ready), 0);
        tick();
        clear      = 1'b0;
        gray_valid = 1'b0;
        sb.delete();
        check("cleared rgb_valid", 32'(rgb_valid), 0);
        check("cleared rgb_out", 32'(rgb_out), 0);
        check("cleared pix_count", 32'(pix_count), 0);
        tick();
        check("clear push dropped", 32'(rgb_valid), 0);

        // Threshold boundary values
        send(8'h7F);
        send(8'h80);
        send(8'hFF);
        repeat (3) tick();
        check("final pix_count", 32'(pix_count), 3);

        check("scoreboard drained", 32'(sb.size()), 0);
        check("total transfers", 32'(n_pops), NPOPS);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
